// File: rtl/sc_ifu.sv
// sc_ifu: instruction fetch unit for the single-cycle MIPS datapath.
//
// Holds the PC and fetches one instruction at a time from instruction
// memory over a req/ack handshake. It then presents the latched word and its
// decoded fields to control and the datapath. When the instruction retires,
// it loads the next PC, chosen by pcsource.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   pcsource              next-PC select: 00 pc4, 01 bpc, 10 rpc, 11 jpc
//   bpc, rpc, jpc         branch / jr / jump targets from the datapath
//   commit                held instruction retires (honoured only in VALID)
//   imem_req, imem_addr   fetch request and address (address == pc)
//   imem_ack, imem_rdata  memory response; data latched on ack in FETCH
//   pc, pc4               held instruction address and its successor
//   inst, inst_valid      latched instruction word and its valid flag
//   op..imm               instruction field slices
//   addr_err              one-cycle pulse after a commit to a misaligned target
//   icount                number of committed instructions (wraps)
module sc_ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        commit,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sa,
    output logic [15:0] imm,
    output logic        addr_err,
    output logic [31:0] icount
);

    typedef enum logic [1:0] {
        RST   = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] target;

    always_comb begin
        target = pc4;
        unique case (pcsource)
            2'b00: target = pc4;
            2'b01: target = bpc;
            2'b10: target = rpc;
            2'b11: target = jpc;
            default: target = pc4;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RST:     state_nxt = FETCH;
            FETCH:   if (imem_ack) state_nxt = VALID;
            VALID:   if (commit)   state_nxt = FETCH;
            default: state_nxt = RST;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RST;
            pc       <= RESET_PC;
            inst     <= '0;
            icount   <= '0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_err <= 1'b0;
            if (state == FETCH && imem_ack) begin
                inst <= imem_rdata;
            end
            if (state == VALID && commit) begin
                // Low bits are forced to zero so the PC stays word-aligned;
                // the misalignment is reported instead of propagated.
                pc       <= {target[31:2], 2'b00};
                icount   <= icount + 32'd1;
                addr_err <= |target[1:0];
            end
        end
    end

    assign imem_req   = (state == FETCH);
    assign imem_addr  = pc;
    assign inst_valid = (state == VALID);
    assign pc4        = pc + 32'd4;

    assign op   = inst[31:26];
    assign rs   = inst[25:21];
    assign rt   = inst[20:16];
    assign rd   = inst[15:11];
    assign sa   = inst[10:6];
    assign func = inst[5:0];
    assign imm  = inst[15:0];

endmodule

// File: tb/tb_sc_ifu.sv
module tb_sc_ifu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = '0, rpc = '0, jpc = '0;
    logic        commit = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc, pc4, inst, icount;
    logic        inst_valid, addr_err;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;

    sc_ifu #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset), .pcsource(pcsource),
        .bpc(bpc), .rpc(rpc), .jpc(jpc), .commit(commit),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc(pc), .pc4(pc4), .inst(inst), .inst_valid(inst_valid),
        .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .imm(imm),
        .addr_err(addr_err), .icount(icount)
    );

    always #5 clock = ~clock;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] addr_q[$];   // expected fetch addresses, pushed at commit/reset
    logic [31:0] inst_q[$];   // expected instruction words, pushed at ack
    logic [31:0] m_icount;
    logic [31:0] m_inst;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] b, r, j;
        logic [31:0] exp_pc;
        logic        exp_err;
        int unsigned waits;
        logic [31:0] rdata;
        logic        hold_commit;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Serve one fetch: verify the request, stall `waits` cycles, then ack.
    task automatic fetch(input logic [31:0] d, input int unsigned waits, input logic hold_commit);
        logic [31:0] exp_addr;
        int unsigned n = 0;
        while (!imem_req && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("req_timeout", {31'd0, imem_req}, 32'd1);
        if (!imem_req) return;
        exp_addr = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hxxxx_xxxx;
        check("imem_addr", imem_addr, exp_addr);
        commit = hold_commit;
        for (int unsigned w = 0; w < waits; w++) begin
            imem_ack = 1'b0;
            @(negedge clock);
            check("req_held", {31'd0, imem_req}, 32'd1);
            check("addr_held", imem_addr, exp_addr);
            check("pc_during_fetch", pc, exp_addr);
            check("icount_during_fetch", icount, m_icount);
            check("no_valid_in_fetch", {31'd0, inst_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = d;
        inst_q.push_back(d);
        @(negedge clock);
        imem_ack   = 1'b0;
        commit     = 1'b0;
        imem_rdata = $urandom;
        m_inst     = inst_q.pop_front();
        check("inst_valid", {31'd0, inst_valid}, 32'd1);
        check("req_dropped", {31'd0, imem_req}, 32'd0);
        check("inst", inst, m_inst);
        check("op", {26'd0, op}, {26'd0, m_inst[31:26]});
        check("rs", {27'd0, rs}, {27'd0, m_inst[25:21]});
        check("rt", {27'd0, rt}, {27'd0, m_inst[20:16]});
        check("rd", {27'd0, rd}, {27'd0, m_inst[15:11]});
        check("sa", {27'd0, sa}, {27'd0, m_inst[10:6]});
        check("func", {26'd0, func}, {26'd0, m_inst[5:0]});
        check("imm", {16'd0, imm}, {16'd0, m_inst[15:0]});
        check("pc4", pc4, exp_addr + 32'd4);
        check("addr_err_low", {31'd0, addr_err}, 32'd0);
    endtask

    task automatic do_commit(input vec_t v);
        // A stray ack while VALID must not disturb the held word.
        imem_ack   = 1'b1;
        imem_rdata = ~m_inst;
        @(negedge clock);
        imem_ack = 1'b0;
        check("ack_ignored_inst", inst, m_inst);
        check("ack_ignored_valid", {31'd0, inst_valid}, 32'd1);
        pcsource = v.src;
        bpc = v.b; rpc = v.r; jpc = v.j;
        commit = 1'b1;
        m_icount++;
        addr_q.push_back(v.exp_pc);
        @(negedge clock);
        commit = 1'b0;
        check("pc_after_commit", pc, v.exp_pc);
        check("icount", icount, m_icount);
        check("addr_err", {31'd0, addr_err}, {31'd0, v.exp_err});
        check("valid_cleared", {31'd0, inst_valid}, 32'd0);
        check("inst_kept", inst, m_inst);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_inst"}, inst, 32'h0);
        check({tag, "_icount"}, icount, 32'h0);
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_addr_err"}, {31'd0, addr_err}, 32'd0);
    endtask

    initial begin
        //           src    bpc            rpc            jpc            exp_pc         err  wait rdata          hold
        vecs[0] = '{2'b00, 32'h0,         32'h0,         32'h0,         32'h0000_0004, 1'b0, 3, 32'h0109_5020, 1'b0};
        vecs[1] = '{2'b01, 32'h0000_0040, 32'h0,         32'h0,         32'h0000_0040, 1'b0, 0, 32'h1000_FFFF, 1'b0};
        vecs[2] = '{2'b10, 32'h0,         32'h0000_0100, 32'h0,         32'h0000_0100, 1'b0, 1, 32'h03E0_0008, 1'b0};
        vecs[3] = '{2'b11, 32'h0,         32'h0,         32'h0040_0000, 32'h0040_0000, 1'b0, 0, 32'h0810_0000, 1'b0};
        vecs[4] = '{2'b10, 32'h0,         32'h0000_0103, 32'h0,         32'h0000_0100, 1'b1, 2, 32'hAC43_0010, 1'b0};
        vecs[5] = '{2'b11, 32'h0,         32'h0,         32'h0000_0002, 32'h0000_0000, 1'b1, 0, 32'h8C22_FFFC, 1'b0};
        vecs[6] = '{2'b01, 32'hFFFF_FFFC, 32'h0,         32'h0,         32'hFFFF_FFFC, 1'b0, 1, 32'h0000_0000, 1'b0};
        vecs[7] = '{2'b00, 32'h0,         32'h0,         32'h0,         32'h0000_0000, 1'b0, 2, 32'h3C01_1234, 1'b1};

        m_icount = '0;
        m_inst   = '0;
        repeat (2) @(negedge clock);
        reset_checks("reset");

        reset = 1'b0;
        addr_q.push_back(32'h0);
        fetch(32'h2008_0005, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            do_commit(vecs[i]);
            fetch(vecs[i].rdata, vecs[i].waits, vecs[i].hold_commit);
        end

        // Reset while a fetch is outstanding; the ack arriving on the same edge is dropped.
        do_commit('{2'b01, 32'h0000_0200, 32'h0, 32'h0, 32'h0000_0200, 1'b0, 0, 32'h0, 1'b0});
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        imem_ack = 1'b0;
        reset_checks("rst_fetch");
        void'(addr_q.pop_front());
        m_icount = '0;
        reset = 1'b0;
        addr_q.push_back(32'h0);
        fetch(32'h2409_0007, 1, 1'b0);

        // Reset on a commit edge: no PC update, no count.
        pcsource = 2'b01; bpc = 32'h0000_0080;
        commit = 1'b1;
        reset  = 1'b1;
        @(negedge clock);
        commit = 1'b0;
        reset_checks("rst_commit");
        reset = 1'b0;
        addr_q.push_back(32'h0);
        fetch(32'h0000_000C, 0, 1'b0);
        check("icount_final", icount, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
